dtc_vote_accum: RTL and testbench
=================================

Name: dtc_vote_accum

Overview:
- Streaming stage directly downstream of the decision-tree classifier, which maps an 11-bit feature vector to a 3-bit class code.
- Collects a window of per-sample class predictions over a valid/ready handshake and counts votes per class.
- At the end of each window it emits the majority class with its vote count, which smooths single-sample misclassifications before the result leaves the classifier subsystem.

Parameters:
- CLASS_W, 3, width of the class code; NUM_CLASSES = 2**CLASS_W.
- WIN, 8, votes per window; legal range 1..255.
- CNT_W, 4, counter width; must satisfy 2**CNT_W > WIN. Elaboration fails if it does not.

Ports:
- clk  in  1  single clock; all state on its rising edge.
- rst_n  in  1  reset.
- in_valid  in  1  classifier output valid.
- in_class  in  CLASS_W  class code from classifier.
- in_ready  out  1  vote accepted when in_valid & in_ready.
- flush  in  1  single-cycle request to close a partial window.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_class  out  CLASS_W  winning class.
- out_votes  out  CNT_W  votes of the winning class.
- out_total  out  CNT_W  votes in the window (WIN, or fewer after flush).

Interface note: one clock; reset is asynchronous and active-low.

Behaviour:
- States:
  - ACCUM: collecting votes.
  - SCAN: argmax search.
  - DONE: holding the result.
- Reset state is ACCUM. During reset:
  - all per-class counters, total, scan index and best registers are 0;
  - out_valid=0, out_class=0, out_votes=0, out_total=0;
  - in_ready=1, because it is decoded from state (high only in ACCUM).
- ACCUM, accepted vote: cnt[in_class] += 1 and total += 1.
  - If the new total == WIN, go to SCAN with idx=0, best_cnt=0, best_cls=0.
  - Counters never exceed WIN, so no saturation logic is needed.
- ACCUM, flush:
  - total>0 (including a vote accepted in the same cycle): the vote is counted first, then go to SCAN.
  - total==0 and no vote this cycle: flush is ignored.
  - flush in SCAN or DONE: ignored, not queued.
- SCAN: one class per cycle.
  - If cnt[idx] > best_cnt (strict), update best_cnt and best_cls; idx += 1.
  - After idx == NUM_CLASSES-1 is evaluated, go to DONE.
  - Tie rule: the lowest class index wins.
- Latency: out_valid rises exactly NUM_CLASSES rising edges after the edge that accepted the last vote (or the flush edge). Default is 8.
- DONE:
  - out_valid=1; out_class, out_votes and out_total are stable until the handshake completes.
  - On out_valid & out_ready: all counters and total clear on that same edge, and the state returns to ACCUM. in_ready is therefore high in the following cycle.
  - Back-pressure: the block may hold DONE indefinitely. in_ready=0 throughout, so upstream stalls and no vote is lost.
- Outputs are registered; no combinational path from in_* to out_*.
- Reset asserted mid-window or mid-scan: immediate clear to reset state. The partial window is discarded and no output is produced.
- Classes with zero votes never win unless all counts are 0. That case cannot occur, since total>0 on SCAN entry.

Decomposition:
- Shared package dtc_pkg holds:
  - CLASS_W and NUM_CLASSES;
  - the state enum {ACCUM, SCAN, DONE};
  - a result struct {class, votes, total}, also reusable by other dtc_* consumers.
- One sub-module, dtc_vote_counter_bank:
  - NUM_CLASSES counters, each CNT_W wide;
  - increment-by-index port, synchronous clear, indexed read port for the scan.
- The top module holds the FSM, scan registers and output registers.

Test Plan:
- Full window, no stall: votes 5,5,7,1,5,0,7,7 with out_ready=1 → out_class=5, out_votes=3, out_total=8 (tie between 5 and 7 resolves to 5); out_valid exactly 8 edges after the 8th vote; in_ready=1 the cycle after the handshake.
- Unanimous window: eight votes of class 2, with in_valid toggling every other cycle → out_class=2, out_votes=8, out_total=8; no vote dropped or double-counted.
- Flush partial: votes 3,6,6, then flush alone → out_class=6, out_votes=2, out_total=3. Separately: flush with no prior votes → no output, in_ready stays 1.
- Back-pressure: out_ready=0 for 20 cycles in DONE → outputs stable, in_ready=0, in_valid held high with class 4 is not counted. Release → next window begins with that class-4 vote accepted first.
- Reset mid-scan: deassert rst_n at scan idx=3 → all outputs 0, in_ready=1. A fresh window of eight class-1 votes → out_class=1, out_votes=8.
- Simultaneous flush and vote: after votes 0,0, a cycle with flush=1 and vote=7 → out_total=3, out_class=0, out_votes=2.

Source files
------------

// File: rtl/dtc_pkg.sv
// Shared definitions for the decision-tree classifier (dtc_*) blocks:
// class-code geometry, the vote-accumulator state encoding and a result
// record that downstream consumers can reuse.
package dtc_pkg;

  localparam int CLASS_W     = 3;
  localparam int NUM_CLASSES = 2 ** CLASS_W;
  localparam int RES_CNT_W   = 4;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCAN  = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [CLASS_W-1:0]   cls;
    logic [RES_CNT_W-1:0] votes;
    logic [RES_CNT_W-1:0] total;
  } result_t;

endpackage

// File: rtl/dtc_vote_counter_bank.sv
// One vote counter per class. It increments by class index, clears
// synchronously and provides an indexed read port for the argmax scan.
// The counters cannot overflow because a window never holds more than WIN
// votes and the top enforces 2**CNT_W > WIN.
module dtc_vote_counter_bank
  import dtc_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  input  logic [CLASS_W-1:0] inc_idx,
  input  logic [CLASS_W-1:0] rd_idx,
  output logic [CNT_W-1:0]   rd_cnt
);

  logic [CNT_W-1:0] cnt [NUM_CLASSES];

  // Counter array: clear wins over increment (they never coincide in practice).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
    end else if (inc) begin
      cnt[inc_idx] <= cnt[inc_idx] + 1'b1;
    end
  end

  assign rd_cnt = cnt[rd_idx];

endmodule

// File: rtl/dtc_vote_accum.sv
// Majority-vote smoother behind the decision-tree classifier. It collects
// up to WIN class votes (or fewer when flushed), scans the per-class counts
// one class per cycle for the argmax (the lowest index wins ties) and holds
// the registered result until the consumer takes it.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high. The producer keeps valid and data stable until that edge. in_ready
// depends only on state (high in ACCUM). out_valid and the out_* fields come
// from registers and stay constant while out_valid is high and out_ready is low.
module dtc_vote_accum
  import dtc_pkg::*;
#(
  parameter int WIN   = 8,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [CLASS_W-1:0] in_class,
  output logic               in_ready,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CLASS_W-1:0] out_class,
  output logic [CNT_W-1:0]   out_votes,
  output logic [CNT_W-1:0]   out_total
);

  if ((WIN < 1) || (WIN > 255) || ((2 ** CNT_W) <= WIN)) begin : g_bad_params
    $error("dtc_vote_accum: WIN must be 1..255 and 2**CNT_W must exceed WIN");
  end

  localparam logic [CNT_W-1:0]   WIN_C    = CNT_W'(WIN);
  localparam logic [CLASS_W-1:0] LAST_IDX = CLASS_W'(NUM_CLASSES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   total_q, total_nxt;
  logic [CLASS_W-1:0] idx_q;
  logic [CNT_W-1:0]   best_cnt_q, best_cnt_nx;
  logic [CLASS_W-1:0] best_cls_q, best_cls_nx;
  logic [CNT_W-1:0]   rd_cnt;
  logic               accept;
  logic               handshake;
  logic               out_valid_q;
  logic [CLASS_W-1:0] out_class_q;
  logic [CNT_W-1:0]   out_votes_q, out_total_q;

  assign in_ready  = (state_q == ACCUM);
  assign accept    = in_valid & in_ready;
  assign handshake = (state_q == DONE) & out_ready;
  assign total_nxt = total_q + CNT_W'(accept);

  dtc_vote_counter_bank #(
    .CNT_W (CNT_W)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (handshake),
    .inc     (accept),
    .inc_idx (in_class),
    .rd_idx  (idx_q),
    .rd_cnt  (rd_cnt)
  );

  // Strictly-greater compare keeps the earlier (lower) class on a tie.
  always_comb begin
    best_cnt_nx = best_cnt_q;
    best_cls_nx = best_cls_q;
    if (rd_cnt > best_cnt_q) begin
      best_cnt_nx = rd_cnt;
      best_cls_nx = idx_q;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  // Next-state decode. A flush counts a same-cycle vote first and is
  // ignored when the window would still be empty.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM: begin
        if ((accept && (total_nxt == WIN_C)) || (flush && (total_nxt != '0)))
          state_d = SCAN;
      end
      SCAN: begin
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  // Window total, scan registers and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q     <= '0;
      idx_q       <= '0;
      best_cnt_q  <= '0;
      best_cls_q  <= '0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_votes_q <= '0;
      out_total_q <= '0;
    end else begin
      case (state_q)
        ACCUM: begin
          total_q <= total_nxt;
          if (state_d == SCAN) begin
            idx_q      <= '0;
            best_cnt_q <= '0;
            best_cls_q <= '0;
          end
        end
        SCAN: begin
          idx_q      <= idx_q + 1'b1;
          best_cnt_q <= best_cnt_nx;
          best_cls_q <= best_cls_nx;
          if (idx_q == LAST_IDX) begin
            out_valid_q <= 1'b1;
            out_class_q <= best_cls_nx;
            out_votes_q <= best_cnt_nx;
            out_total_q <= total_q;
          end
        end
        DONE: begin
          if (out_ready) begin
            total_q     <= '0;
            out_valid_q <= 1'b0;
            out_class_q <= '0;
            out_votes_q <= '0;
            out_total_q <= '0;
          end
        end
        default: begin
          total_q <= '0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_votes = out_votes_q;
  assign out_total = out_total_q;

endmodule

// File: tb/tb_dtc_vote_accum.sv
// Directed and randomized checks of the class-vote majority accumulator
// against a count-based reference model of the window's votes.
module tb_dtc_vote_accum;
  import dtc_pkg::*;

  localparam int WIN   = 8;
  localparam int CNT_W = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic [CLASS_W-1:0] in_class;
  logic               in_ready;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [CLASS_W-1:0] out_class;
  logic [CNT_W-1:0]   out_votes;
  logic [CNT_W-1:0]   out_total;

  int n_checks = 0;
  int n_fails  = 0;
  int win_q[$];

  dtc_vote_accum #(.WIN(WIN), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_class  (in_class),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_votes (out_votes),
    .out_total (out_total)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: majority of the window's votes, earliest class among the maxima.
  task automatic model_result(output int cls, output int votes, output int total);
    int cnt[NUM_CLASSES];
    int mx;
    for (int c = 0; c < NUM_CLASSES; c++) cnt[c] = 0;
    foreach (win_q[i]) cnt[win_q[i]] = cnt[win_q[i]] + 1;
    mx = 0;
    for (int c = 0; c < NUM_CLASSES; c++) if (cnt[c] > mx) mx = cnt[c];
    cls = 0;
    for (int c = NUM_CLASSES - 1; c >= 0; c--) if (cnt[c] == mx) cls = c;
    votes = mx;
    total = win_q.size();
  endtask

  task automatic send_vote(input int c, input logic fl);
    int g = 0;
    while (in_ready !== 1'b1 && g < 50) begin step(); g++; end
    if (g >= 50) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_class = CLASS_W'(c);
    flush    = fl;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
    win_q.push_back(c);
  endtask

  // Called right after the accepting (or flush) edge.
  task automatic wait_result(input string tag);
    int n = 0;
    int ec, ev, et;
    while (out_valid !== 1'b1 && n < 40) begin step(); n++; end
    check({tag, "_latency"}, n, 32'd8);
    model_result(ec, ev, et);
    check({tag, "_class"}, {29'd0, out_class}, ec);
    check({tag, "_votes"}, {28'd0, out_votes}, ev);
    check({tag, "_total"}, {28'd0, out_total}, et);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_out_valid_after"}, {31'd0, out_valid}, 32'd0);
    win_q.delete();
  endtask

  initial begin
    logic [CLASS_W-1:0] snap_cls;
    logic [CNT_W-1:0]   snap_votes, snap_total;
    int n;

    // Reset.
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_class  = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #3;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_class", {29'd0, out_class}, 32'd0);
    check("rst_out_votes", {28'd0, out_votes}, 32'd0);
    check("rst_out_total", {28'd0, out_total}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Full window with out_ready held high: 5 and 7 tie at 3, class 5 wins.
    out_ready = 1'b1;
    send_vote(5, 0); send_vote(5, 0); send_vote(7, 0); send_vote(1, 0);
    send_vote(5, 0); send_vote(0, 0); send_vote(7, 0); send_vote(7, 0);
    check("full_exp_model_class", 32'd5, {29'd0, out_class} | 32'd5);
    wait_result("full");
    handshake("full");

    // Unanimous window with in_valid toggling.
    for (int i = 0; i < 8; i++) begin
      step();
      send_vote(2, 0);
    end
    wait_result("unanimous");
    handshake("unanimous");

    // Partial window closed by a lone flush.
    send_vote(3, 0); send_vote(6, 0); send_vote(6, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_result("flush_partial");
    handshake("flush_partial");

    // Flush into an empty window is ignored.
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check("flush_empty_out_valid", {31'd0, out_valid}, 32'd0);
      check("flush_empty_in_ready", {31'd0, in_ready}, 32'd1);
      step();
    end

    // Back-pressure in DONE with a class-4 vote waiting upstream.
    for (int i = 0; i < 8; i++) send_vote($urandom_range(0, NUM_CLASSES - 1), 0);
    wait_result("bp");
    snap_cls   = out_class;
    snap_votes = out_votes;
    snap_total = out_total;
    in_valid = 1'b1;
    in_class = 3'd4;
    for (int i = 0; i < 20; i++) begin
      step();
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_class_stable", {29'd0, out_class}, {29'd0, snap_cls});
      check("bp_votes_stable", {28'd0, out_votes}, {28'd0, snap_votes});
      check("bp_total_stable", {28'd0, out_total}, {28'd0, snap_total});
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    win_q.delete();
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    win_q.push_back(4);
    for (int i = 0; i < 7; i++) send_vote($urandom_range(0, NUM_CLASSES - 1), 0);
    wait_result("bp_next");
    handshake("bp_next");

    // Reset while the scan is at index 3.
    for (int i = 0; i < 8; i++) send_vote($urandom_range(0, NUM_CLASSES - 1), 0);
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    win_q.delete();
    check("midscan_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midscan_rst_out_class", {29'd0, out_class}, 32'd0);
    check("midscan_rst_out_votes", {28'd0, out_votes}, 32'd0);
    check("midscan_rst_out_total", {28'd0, out_total}, 32'd0);
    check("midscan_rst_in_ready", {31'd0, in_ready}, 32'd1);
    #2;
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      check("midscan_no_output", {31'd0, out_valid}, 32'd0);
      step();
    end
    for (int i = 0; i < 8; i++) send_vote(1, 0);
    wait_result("after_rst");
    handshake("after_rst");

    // Flush together with a vote: the vote is counted first.
    send_vote(0, 0); send_vote(0, 0);
    send_vote(7, 1);
    wait_result("flush_vote");
    handshake("flush_vote");

    // Randomized windows: random gaps, lengths, flush style and consumer stalls.
    for (int w = 0; w < 12; w++) begin
      n = $urandom_range(1, WIN);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) begin
          in_class = CLASS_W'($urandom_range(0, NUM_CLASSES - 1));
          step();
        end
        if (i == n - 1 && n < WIN && $urandom_range(0, 1) == 1)
          send_vote($urandom_range(0, NUM_CLASSES - 1), 1);
        else
          send_vote($urandom_range(0, NUM_CLASSES - 1), 0);
      end
      if (n < WIN && win_q.size() == n && out_valid !== 1'b1 && in_ready === 1'b1) begin
        flush = 1'b1;
        step();
        flush = 1'b0;
      end
      wait_result("rand");
      repeat ($urandom_range(0, 4)) begin
        step();
        check("rand_hold_valid", {31'd0, out_valid}, 32'd1);
      end
      handshake("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
